// File: rtl/cheshire_uart_rx_sink.sv
// UART receiver for the SoC fixture: oversampled RX line, 8-bit framing with optional parity,
// received bytes buffered in a FIFO and presented on a valid/ready stream.
module cheshire_uart_rx_sink #(
  parameter int unsigned FifoDepth = 8,
  parameter int unsigned DivWidth  = 16,
  parameter bit          ParityEn  = 1'b0,
  parameter bit          ParityOdd = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DivWidth-1:0] clk_div_i,
  input  logic                uart_rx_i,
  output logic [7:0]          data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                frame_err_o,
  output logic                parity_err_o,
  output logic                overflow_o,
  output logic                busy_o
);

  localparam int unsigned AW = $clog2(FifoDepth);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  state_e              state_q, state_d;
  logic [DivWidth-1:0] cnt_q, cnt_d, div_q, div_d, div_clamp;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shreg_q, shreg_d;
  logic                par_bad_q, par_bad_d;
  logic                push_q, push_d;
  logic                frame_err_q, frame_err_d;
  logic                parity_err_q, parity_err_d;
  logic                overflow_q, overflow_d;
  logic                sync1_q, sync2_q, line_q;
  logic                fall, tick;

  logic [7:0]  mem_q [FifoDepth];
  logic [AW:0] wptr_q, rptr_q;
  logic        empty, full, pop, wr_en;

  // Synchronizer idles high so reset release never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      line_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
      line_q  <= sync2_q;
    end
  end

  assign fall      = line_q & ~sync2_q;
  assign tick      = (cnt_q == '0);
  assign div_clamp = (clk_div_i < DivWidth'(4)) ? DivWidth'(4) : clk_div_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    par_bad_d    = par_bad_q;
    push_d       = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          div_d     = div_clamp;
          cnt_d     = div_clamp >> 1;
          idx_d     = 3'd0;
          par_bad_d = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (!tick) begin
          cnt_d = cnt_q - DivWidth'(1);
        end else if (sync2_q) begin
          state_d = StIdle;
        end else begin
          cnt_d   = div_q - DivWidth'(1);
          state_d = StData;
        end
      end
      StData: begin
        if (!tick) begin
          cnt_d = cnt_q - DivWidth'(1);
        end else begin
          shreg_d[idx_q] = sync2_q;
          cnt_d          = div_q - DivWidth'(1);
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ParityEn ? StParity : StStop;
        end
      end
      StParity: begin
        if (!tick) begin
          cnt_d = cnt_q - DivWidth'(1);
        end else begin
          par_bad_d = sync2_q != ((^shreg_q) ^ ParityOdd);
          cnt_d     = div_q - DivWidth'(1);
          state_d   = StStop;
        end
      end
      StStop: begin
        if (!tick) begin
          cnt_d = cnt_q - DivWidth'(1);
        end else if (sync2_q) begin
          push_d       = 1'b1;
          parity_err_d = par_bad_q;
          state_d      = StIdle;
        end else begin
          frame_err_d = 1'b1;
          state_d     = StBreak;
        end
      end
      StBreak: begin
        if (sync2_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      div_q        <= DivWidth'(4);
      idx_q        <= 3'd0;
      shreg_q      <= 8'h00;
      par_bad_q    <= 1'b0;
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      par_bad_q    <= par_bad_d;
      push_q       <= push_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overflow_q   <= overflow_d;
    end
  end

  // shreg_q is untouched while push_q is high, so it serves as the write data.
  assign empty      = (wptr_q == rptr_q);
  assign full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop        = valid_o && ready_i;
  assign wr_en      = push_q && (!full || pop);
  assign overflow_d = push_q && full && !pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
      if (pop)   rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= shreg_q;
  end

  assign valid_o      = !empty;
  assign data_o       = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_cheshire_uart_rx_sink.sv
// Directed + randomized bench: a line driver builds UART frames, a monitor collects popped bytes
// and error pulses, and expected bytes come from a queue model of what was sent.
module tb_cheshire_uart_rx_sink;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] div;
  logic        rx, rx_p;
  logic        ready, ready_main, ready_rand, rand_ph;
  logic [7:0]  data, data_p;
  logic        valid, valid_p, ferr, ferr_p, perr, perr_p, ovf, ovf_p, busy, busy_p;

  always #5 clk = ~clk;
  assign ready = rand_ph ? ready_rand : ready_main;

  cheshire_uart_rx_sink u_dut (
    .clk_i(clk), .rst_ni(rst_n), .clk_div_i(div), .uart_rx_i(rx), .data_o(data),
    .valid_o(valid), .ready_i(ready), .frame_err_o(ferr), .parity_err_o(perr),
    .overflow_o(ovf), .busy_o(busy)
  );

  cheshire_uart_rx_sink #(.ParityEn(1'b1), .ParityOdd(1'b0)) u_dut_p (
    .clk_i(clk), .rst_ni(rst_n), .clk_div_i(div), .uart_rx_i(rx_p), .data_o(data_p),
    .valid_o(valid_p), .ready_i(ready), .frame_err_o(ferr_p), .parity_err_o(perr_p),
    .overflow_o(ovf_p), .busy_o(busy_p)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc, rise_cyc, rise_p_cyc, perr_p_cyc;
  int n_ferr, n_ovf, n_perr, n_perr_p, n_ferr_p;
  logic valid_prev, valid_p_prev, saw_busy;
  logic [7:0] rxq[$], rxq_p[$], exp_q[$], exp_p[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    ready_rand = 1'b1;
    forever begin
      @(posedge clk);
      #1 ready_rand = 1'($urandom_range(0, 1));
    end
  end

  // Sample on the falling edge; a pop happens at the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) rxq.push_back(data);
      if (valid_p && ready) rxq_p.push_back(data_p);
      if (ferr) n_ferr <= n_ferr + 1;
      if (ferr_p) n_ferr_p <= n_ferr_p + 1;
      if (ovf) n_ovf <= n_ovf + 1;
      if (perr) n_perr <= n_perr + 1;
      if (perr_p) begin
        n_perr_p   <= n_perr_p + 1;
        perr_p_cyc <= cyc;
      end
      if (valid && !valid_prev) rise_cyc <= cyc;
      if (valid_p && !valid_p_prev) rise_p_cyc <= cyc;
      if (busy) saw_busy <= 1'b1;
    end
    valid_prev   <= valid;
    valid_p_prev <= valid_p;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_rx(input string tag, input bit p);
    int ng, ne;
    ng = p ? rxq_p.size() : rxq.size();
    ne = p ? exp_p.size() : exp_q.size();
    chk({tag, "_count"}, 32'(ng), 32'(ne));
    for (int i = 0; i < ng && i < ne; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), p ? 32'(rxq_p[i]) : 32'(rxq[i]),
          p ? 32'(exp_p[i]) : 32'(exp_q[i]));
    end
  endtask

  task automatic clear_obs();
    rxq.delete(); rxq_p.delete(); exp_q.delete(); exp_p.delete();
    n_ferr = 0; n_ovf = 0; n_perr = 0; n_perr_p = 0; n_ferr_p = 0; saw_busy = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input bit p, input logic v);
    if (p) rx_p = v;
    else rx = v;
  endtask

  // One frame, LSB first; parbit < 0 means no parity bit. The stop level is left on the line.
  task automatic send(input bit p, input logic [7:0] b, input int bitc, input logic stop,
                      input int parbit);
    set_line(p, 1'b0);
    start_cyc = cyc;
    wait_cyc(bitc);
    for (int i = 0; i < 8; i++) begin
      set_line(p, b[i]);
      wait_cyc(bitc);
    end
    if (parbit >= 0) begin
      set_line(p, parbit[0]);
      wait_cyc(bitc);
    end
    set_line(p, stop);
    wait_cyc(bitc);
  endtask

  initial begin
    logic [7:0] b;
    int d;
    rst_n = 1'b0; rx = 1'b1; rx_p = 1'b1; div = 16'd16; ready_main = 1'b1; rand_ph = 1'b0;
    clear_obs();
    @(posedge clk);
    wait_cyc(2);
    chk("rst_outputs", {24'h0, data, valid, ferr, perr, ovf, busy, 3'b0},
        {24'h0, 8'h00, 8'h00});
    rst_n = 1'b1;
    wait_cyc(5);

    // 0x55 8N1 at div 16
    clear_obs();
    exp_q.push_back(8'h55);
    send(0, 8'h55, 16, 1'b1, -1);
    wait_cyc(32);
    chk_rx("byte55", 0);
    d = rise_cyc - start_cyc;
    chk("latency55", 32'((d >= 155) && (d <= 158)), 32'd1);
    chk("err55", 32'(n_ferr + n_perr + n_ovf), 32'd0);

    // short glitch
    clear_obs();
    rx = 1'b0;
    wait_cyc(5);
    rx = 1'b1;
    wait_cyc(40);
    chk("glitch_busy_seen", 32'(saw_busy), 32'd1);
    chk("glitch_busy_end", 32'(busy), 32'd0);
    chk("glitch_nobyte", 32'(rxq.size() + n_ferr), 32'd0);

    // framing error followed by a break, then a good frame
    clear_obs();
    send(0, 8'h3C, 16, 1'b0, -1);
    wait_cyc(200);
    chk("break_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_cyc(40);
    exp_q.push_back(8'hA3);
    send(0, 8'hA3, 16, 1'b1, -1);
    wait_cyc(40);
    chk("ferr_count", 32'(n_ferr), 32'd1);
    chk_rx("after_break", 0);

    // overflow on the ninth byte
    clear_obs();
    ready_main = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = 8'(i);
      if (i < 8) exp_q.push_back(b);
      send(0, b, 16, 1'b1, -1);
      wait_cyc(20);
      if (i == 7) chk("ovf_before9", 32'(n_ovf), 32'd0);
    end
    chk("ovf_after9", 32'(n_ovf), 32'd1);
    chk("ovf_head_hold", {23'h0, valid, data}, {23'h0, 1'b1, 8'h00});
    ready_main = 1'b1;
    wait_cyc(20);
    chk_rx("ovf_drain", 0);
    chk("ovf_empty", 32'(valid), 32'd0);

    // parity: even parity for 0x07 is 1
    clear_obs();
    exp_p.push_back(8'h07);
    exp_p.push_back(8'h07);
    send(1, 8'h07, 16, 1'b1, 1);
    wait_cyc(32);
    chk("par_ok", 32'(n_perr_p), 32'd0);
    send(1, 8'h07, 16, 1'b1, 0);
    wait_cyc(32);
    chk("par_bad", 32'(n_perr_p), 32'd1);
    chk("par_with_push", 32'(rise_p_cyc - perr_p_cyc), 32'd1);
    chk("par_no_ferr", 32'(n_ferr_p), 32'd0);
    chk_rx("par_bytes", 1);

    // reset in the middle of a frame with bytes queued
    clear_obs();
    ready_main = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(0, 8'(8'hC0 + i), 16, 1'b1, -1);
      wait_cyc(20);
    end
    chk("rst_queued", 32'(valid), 32'd1);
    rx = 1'b0;
    wait_cyc(60);
    chk("rst_busy_mid", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {24'h0, data, valid, ferr, perr, ovf, busy, 3'b0},
        {24'h0, 8'h00, 8'h00});
    rx = 1'b1;
    wait_cyc(4);
    rst_n = 1'b1;
    ready_main = 1'b1;
    wait_cyc(10);
    chk("rst_after_idle", {30'h0, valid, busy}, 32'd0);
    clear_obs();
    exp_q.push_back(8'h81);
    send(0, 8'h81, 16, 1'b1, -1);
    wait_cyc(32);
    chk_rx("rst_then81", 0);

    // divider below the minimum is clamped to 4
    clear_obs();
    div = 16'd3;
    exp_q.push_back(8'hF0);
    send(0, 8'hF0, 4, 1'b1, -1);
    wait_cyc(20);
    chk_rx("clamp", 0);

    // random bytes, random dividers, random backpressure
    clear_obs();
    rand_ph = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = $urandom_range(4, 24);
      div = 16'(d);
      b = 8'($urandom);
      exp_q.push_back(b);
      send(0, b, d, 1'b1, -1);
      wait_cyc($urandom_range(2 * d, 4 * d));
    end
    rand_ph = 1'b0;
    ready_main = 1'b1;
    wait_cyc(40);
    chk_rx("rand", 0);
    chk("rand_errs", 32'(n_ovf + n_ferr), 32'd0);
    chk("main_no_perr", 32'(n_perr), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
